i2c_txn_sequencer: RTL and testbench

Command front-end that sits directly upstream of the byte-level I2C master and drives its addr/data/packets/start/rw inputs. It accepts one transaction command (7-bit slave address, direction, length 1..16 bytes) from the printbot control logic. Write payload comes from a 16-byte TX buffer. Read bytes are captured into a 16-byte RX buffer. It also serves the master's data_req/data_ready byte handshake and pulses done when the master returns to idle.

---
 rtl/i2c_txn_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// rtl/i2c_txn_sequencer.sv - transaction command front-end driving the byte-level I2C master
module i2c_txn_sequencer #(
  parameter int START_TIMEOUT = 8,
  parameter int MAX_LEN       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [4:0] cmd_len,
  input  logic       tx_we,
  input  logic [3:0] tx_waddr,
  input  logic [7:0] tx_wdata,
  input  logic [3:0] rx_raddr,
  output logic [7:0] rx_rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] rx_count,
  output logic [6:0] m_addr,
  output logic [7:0] m_data,
  output logic [4:0] m_packets,
  output logic       m_start,
  output logic       m_rw,
  input  logic       m_ready,
  input  logic       m_data_req,
  input  logic       m_data_ready,
  input  logic [7:0] m_data_out
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

  state_t          state_q, state_d;
  logic [7:0]      tx_buf_q [MAX_LEN];
  logic [7:0]      rx_buf_q [MAX_LEN];
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [4:0]      rx_count_q, rx_count_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic [7:0]      m_data_q, m_data_d;
  logic [4:0]      m_packets_q, m_packets_d;
  logic            m_start_q, m_start_d, m_rw_q, m_rw_d;
  logic [3:0]      tx_ptr_q, tx_ptr_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            req_prev_q;
  logic [7:0]      rx_rdata_q;
  logic            len_ok, accept, tx_wr_en, rx_wr_en;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rx_count_d  = rx_count_q;
    m_addr_d    = m_addr_q;
    m_data_d    = m_data_q;
    m_packets_d = m_packets_q;
    m_start_d   = m_start_q;
    m_rw_d      = m_rw_q;
    tx_ptr_d    = tx_ptr_q;
    tmr_d       = tmr_q;
    accept      = 1'b0;
    rx_wr_en    = 1'b0;
    len_ok      = (cmd_len != 5'd0) && (cmd_len <= 5'(MAX_LEN));
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (len_ok) begin
            accept      = 1'b1;
            m_addr_d    = cmd_addr;
            m_rw_d      = cmd_rw;
            m_packets_d = cmd_len;
            m_data_d    = tx_buf_q[0];
            m_start_d   = 1'b1;
            tx_ptr_d    = 4'd0;
            rx_count_d  = 5'd0;
            tmr_d       = '0;
            err_d       = 1'b0;
            busy_d      = 1'b1;
            state_d     = LAUNCH;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      LAUNCH: begin
        if (!m_ready) begin
          m_start_d = 1'b0;
          state_d   = RUN;
        end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
          m_start_d = 1'b0;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RUN: begin
        if (m_rw_q) begin
          if (m_data_ready) begin
            if (rx_count_q < 5'(MAX_LEN)) begin
              rx_wr_en   = 1'b1;
              rx_count_d = rx_count_q + 5'd1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (req_prev_q && !m_data_req) begin
          // Advance only after data_req falls: the master samples m_data twice per byte.
          tx_ptr_d = tx_ptr_q + 4'd1;
          m_data_d = tx_buf_q[tx_ptr_q + 4'd1];
        end
        if (m_ready) state_d = FINISH;
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_wr_en = reset && tx_we && !busy_q && !(accept && (tx_waddr == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rx_count_q  <= 5'd0;
      m_addr_q    <= 7'd0;
      m_data_q    <= 8'd0;
      m_packets_q <= 5'd0;
      m_start_q   <= 1'b0;
      m_rw_q      <= 1'b0;
      tx_ptr_q    <= 4'd0;
      tmr_q       <= '0;
      req_prev_q  <= 1'b0;
      rx_rdata_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rx_count_q  <= rx_count_d;
      m_addr_q    <= m_addr_d;
      m_data_q    <= m_data_d;
      m_packets_q <= m_packets_d;
      m_start_q   <= m_start_d;
      m_rw_q      <= m_rw_d;
      tx_ptr_q    <= tx_ptr_d;
      tmr_q       <= tmr_d;
      req_prev_q  <= m_data_req;
      rx_rdata_q  <= rx_buf_q[rx_raddr];
    end
  end

  // Buffer contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (tx_wr_en) tx_buf_q[tx_waddr] <= tx_wdata;
    if (reset && rx_wr_en) rx_buf_q[rx_count_q[3:0]] <= m_data_out;
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rx_count  = rx_count_q;
  assign rx_rdata  = rx_rdata_q;
  assign m_addr    = m_addr_q;
  assign m_data    = m_data_q;
  assign m_packets = m_packets_q;
  assign m_start   = m_start_q;
  assign m_rw      = m_rw_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb/tb_i2c_txn_sequencer.sv - directed self-checking bench for i2c_txn_sequencer
module tb_i2c_txn_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [4:0] cmd_len;
  logic       tx_we;
  logic [3:0] tx_waddr, rx_raddr;
  logic [7:0] tx_wdata, rx_rdata;
  logic       busy, done, err;
  logic [4:0] rx_count;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic [4:0] m_packets;
  logic       m_start, m_rw;
  logic       m_ready, m_data_req, m_data_ready;
  logic [7:0] m_data_out;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] bus [17];

  always #5 clk = ~clk;

  i2c_txn_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .tx_we(tx_we), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
    .rx_raddr(rx_raddr), .rx_rdata(rx_rdata),
    .busy(busy), .done(done), .err(err), .rx_count(rx_count),
    .m_addr(m_addr), .m_data(m_data), .m_packets(m_packets),
    .m_start(m_start), .m_rw(m_rw),
    .m_ready(m_ready), .m_data_req(m_data_req),
    .m_data_ready(m_data_ready), .m_data_out(m_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] a, input logic rw, input logic [4:0] len);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Behavioural master: drops ready, requests n bytes, then returns to idle.
  task automatic master_write(input int n);
    bus[0]  = {m_addr, m_rw};
    m_ready = 1'b0;
    tick();
    check("run_mstart_low", 32'(m_start), 32'd0);
    for (int i = 0; i < n; i++) begin
      m_data_req = 1'b1;
      tick();
      tick();
      bus[i+1]   = m_data;
      m_data_req = 1'b0;
      tick();
    end
    m_ready = 1'b1;
    tick();
  endtask

  task automatic master_read(input logic [23:0] v, input int n);
    bus[0]  = {m_addr, m_rw};
    m_ready = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      m_data_out   = v[23-8*i -: 8];
      m_data_ready = 1'b1;
      tick();
      m_data_ready = 1'b0;
      tick();
    end
    m_ready = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'd0; cmd_len = 5'd0;
    tx_we = 1'b0; tx_waddr = 4'd0; tx_wdata = 8'd0; rx_raddr = 4'd0;
    m_ready = 1'b1; m_data_req = 1'b0; m_data_ready = 1'b0; m_data_out = 8'd0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_packets", 32'(m_packets), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rx_rdata", 32'(rx_rdata), 32'd0);
    reset = 1'b1;

    tx_we = 1'b1; tx_waddr = 4'd0; tx_wdata = 8'hA5;
    tick();
    tx_waddr = 4'd1; tx_wdata = 8'h3C;
    tick();
    tx_we = 1'b0;

    // Write 0x48, two bytes; a tx_we during busy must be ignored.
    issue(7'h48, 1'b0, 5'd2);
    check("wr_m_start", 32'(m_start), 32'd1);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
    check("wr_m_packets", 32'(m_packets), 32'd2);
    check("wr_m_data0", 32'(m_data), 32'hA5);
    tx_we = 1'b1; tx_waddr = 4'd1; tx_wdata = 8'hFF;
    tick();
    tx_we = 1'b0;
    master_write(2);
    check("wr_bus_addr", 32'(bus[0]), 32'h90);
    check("wr_bus_b0", 32'(bus[1]), 32'hA5);
    check("wr_bus_b1", 32'(bus[2]), 32'h3C);
    check("wr_done_early", 32'(done), 32'd0);
    tick();
    check("wr_done", 32'(done), 32'd1);
    check("wr_busy_end", 32'(busy), 32'd0);
    check("wr_err", 32'(err), 32'd0);
    check("wr_cmd_ready_end", 32'(cmd_ready), 32'd1);
    tick();
    check("wr_done_once", 32'(done), 32'd0);

    // Read 0x48, three bytes.
    issue(7'h48, 1'b1, 5'd3);
    check("rd_m_rw", 32'(m_rw), 32'd1);
    master_read(24'h112233, 3);
    check("rd_bus_addr", 32'(bus[0]), 32'h91);
    check("rd_rx_count", 32'(rx_count), 32'd3);
    tick();
    check("rd_done", 32'(done), 32'd1);
    check("rd_err", 32'(err), 32'd0);
    rx_raddr = 4'd2;
    tick();
    check("rd_buf2", 32'(rx_rdata), 32'h33);
    rx_raddr = 4'd0;
    check("rd_latency", 32'(rx_rdata), 32'h33);
    tick();
    check("rd_buf0", 32'(rx_rdata), 32'h11);
    rx_raddr = 4'd1;
    tick();
    check("rd_buf1", 32'(rx_rdata), 32'h22);

    // Illegal lengths.
    issue(7'h48, 1'b0, 5'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_err", 32'(err), 32'd1);
    check("len0_m_start", 32'(m_start), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_done_once", 32'(done), 32'd0);
    check("len0_err_sticky", 32'(err), 32'd1);
    issue(7'h48, 1'b0, 5'd17);
    check("len17_done", 32'(done), 32'd1);
    check("len17_err", 32'(err), 32'd1);
    check("len17_m_start", 32'(m_start), 32'd0);
    check("len17_m_packets", 32'(m_packets), 32'd3);
    tick();

    // Start timeout with len=16 while the master never drops ready.
    issue(7'h20, 1'b0, 5'd16);
    check("to_err_cleared", 32'(err), 32'd0);
    check("to_m_packets16", 32'(m_packets), 32'd16);
    check("to_m_start", 32'(m_start), 32'd1);
    repeat (7) tick();
    check("to_m_start_7", 32'(m_start), 32'd1);
    check("to_done_7", 32'(done), 32'd0);
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_done", 32'(done), 32'd1);
    check("to_m_start_off", 32'(m_start), 32'd0);
    check("to_cmd_ready", 32'(cmd_ready), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    tick();

    // cmd_valid held high; tx_we to index 0 on the accept cycle is dropped.
    cmd_valid = 1'b1; cmd_addr = 7'h48; cmd_rw = 1'b0; cmd_len = 5'd2;
    tx_we = 1'b1; tx_waddr = 4'd0; tx_wdata = 8'h55;
    tick();
    tx_we = 1'b0; cmd_len = 5'd5;
    check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    check("hold_m_data0", 32'(m_data), 32'hA5);
    master_write(2);
    check("hold_no_reaccept", 32'(m_packets), 32'd2);
    check("hold_cmd_ready_run", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_bus_b0", 32'(bus[1]), 32'hA5);
    check("hold_bus_b1", 32'(bus[2]), 32'h3C);
    tick();
    check("hold_m_start", 32'(m_start), 32'd0);

    // Reset mid-RUN.
    issue(7'h48, 1'b1, 5'd2);
    m_ready = 1'b0;
    tick();
    m_data_out = 8'h5A; m_data_ready = 1'b1;
    tick();
    m_data_ready = 1'b0;
    check("mid_rx_count", 32'(rx_count), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1; m_ready = 1'b1;
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_m_start", 32'(m_start), 32'd0);
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rel_rx_count", 32'(rx_count), 32'd0);
    tick();
    check("rel_no_done", 32'(done), 32'd0);
    check("rel_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
